mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/rr_picker.sv | 40 ++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter.
//   - arb_state_t  : arbiter FSM states
//   - DEF_*        : default parameter values for the arbiter
//   - REQ_*        : requester index assignments on the request ports
//   - idx_width()  : width of an index into NREQ requesters (at least 1 bit)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  localparam int DEF_MEM_W   = 32;
  localparam int DEF_NREQ    = 3;
  localparam int DEF_TIMEOUT = 255;

  localparam int REQ_IBEX_INSTR = 0;
  localparam int REQ_IBEX_DATA  = 1;
  localparam int REQ_VICUNA     = 2;

  // Wide enough for any TIMEOUT in 1..65535.
  localparam int CNT_W = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational cyclic picker: returns the first requester at or after ptr,
// wrapping around modulo NREQ.
// Ports:
//   req    : request vector
//   ptr    : search start index (0..NREQ-1)
//   onehot : one-hot of the chosen requester, zero when no request
//   idx    : index of the chosen requester, zero when no request
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] idx
);

  logic          found;
  logic [IDXW:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k never exceeds 2*NREQ-2, so one conditional subtract wraps it.
      pos = {1'b0, ptr} + (IDXW+1)'(k);
      if (pos >= (IDXW+1)'(NREQ)) pos = pos - (IDXW+1)'(NREQ);
      if (!found && req[pos[IDXW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDXW-1:0];
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto a single downstream
// memory port with at most one outstanding transaction.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i : per-requester request (flattened, req 0 in LSBs)
//   gnt_o           : per-requester grant (one-hot or zero)
//   rvalid_o, err_o : per-requester response valid / error (one-hot or zero)
//   rdata_o         : response data broadcast to all requesters
//   mem_*_o         : downstream request
//   mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i : downstream grant / response
// A response that never arrives is closed after TIMEOUT wait cycles with an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_W   = DEF_MEM_W,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*32-1:0]      addr_i,
  input  logic [NREQ-1:0]         we_i,
  input  logic [NREQ*MEM_W/8-1:0] be_i,
  input  logic [NREQ*MEM_W-1:0]   wdata_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         rvalid_o,
  output logic [NREQ-1:0]         err_o,
  output logic [MEM_W-1:0]        rdata_o,
  output logic                    mem_req_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_we_o,
  output logic [MEM_W/8-1:0]      mem_be_o,
  output logic [MEM_W-1:0]        mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic                    mem_err_i,
  input  logic [MEM_W-1:0]        mem_rdata_i
);

  localparam int IDXW = idx_width(NREQ);
  localparam int BE_W = MEM_W / 8;

  arb_state_t       state_q, state_d;
  logic [IDXW-1:0]  rr_ptr_q;
  logic [IDXW-1:0]  owner_q;
  logic [IDXW-1:0]  sel_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_any;
  logic [IDXW-1:0]  sel;
  logic [IDXW-1:0]  sel_next;

  logic             issue;      // downstream request driven this cycle
  logic             accept;     // downstream grant taken this cycle
  logic             resp_real;  // real response forwarded this cycle
  logic             resp_to;    // timeout response generated this cycle

  rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req    (req_i),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_any = |pick_onehot;

  // Once a request is presented but not granted, the choice is frozen so the
  // downstream request stays stable until it is granted or withdrawn.
  always_comb begin
    sel = (state_q == ST_REQ) ? sel_q : pick_idx;
  end

  assign sel_next = (sel == IDXW'(NREQ-1)) ? '0 : sel + IDXW'(1);

  // State register and control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue && !accept) sel_q <= sel;
      if (accept) begin
        owner_q  <= sel;
        rr_ptr_q <= sel_next;
      end
      if (state_q == ST_WAIT && state_d == ST_WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                                          cnt_q <= '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    accept    = 1'b0;
    resp_real = 1'b0;
    resp_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          issue = 1'b1;
          if (mem_gnt_i) begin
            accept  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_i[sel_q]) begin
          issue = 1'b1;
          if (mem_gnt_i) begin
            accept  = 1'b1;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A real response takes priority over a coincident timeout.
        if (mem_rvalid_i) begin
          resp_real = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          resp_to = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is forced low while reset is held, since the
  // request path is combinational from the inputs.
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    err_o       = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (!rst) begin
      if (issue) begin
        mem_req_o   = 1'b1;
        mem_addr_o  = addr_i[int'(sel)*32 +: 32];
        mem_we_o    = we_i[sel];
        mem_be_o    = be_i[int'(sel)*BE_W +: BE_W];
        mem_wdata_o = wdata_i[int'(sel)*MEM_W +: MEM_W];
      end
      if (accept) gnt_o[sel] = 1'b1;
      if (resp_real) begin
        rvalid_o[owner_q] = 1'b1;
        err_o[owner_q]    = mem_err_i;
        rdata_o           = mem_rdata_i;
      end else if (resp_to) begin
        rvalid_o[owner_q] = 1'b1;
        err_o[owner_q]    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_W = 32;
  localparam int NREQ  = 3;
  localparam int TMO   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ*32-1:0] addr_i;
  logic [NREQ-1:0]   we_i;
  logic [NREQ*4-1:0] be_i;
  logic [NREQ*32-1:0] wdata_i;
  logic [NREQ-1:0]   gnt_o, rvalid_o, err_o;
  logic [31:0]       rdata_o;
  logic              mem_req_o;
  logic [31:0]       mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt_i = 1'b0;
  logic              mem_rvalid_i = 1'b0;
  logic              mem_err_i = 1'b0;
  logic [31:0]       mem_rdata_i = '0;

  mem_arbiter #(.MEM_W(MEM_W), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0]  rv;
    logic [2:0]  err;
    logic [31:0] rdata;
  } resp_t;

  resp_t sb[$];

  typedef struct {
    logic [2:0]  req;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  x_gnt;
    logic [2:0]  x_rv;
    logic [2:0]  x_err;
    logic [31:0] x_rdata;
    logic        x_mreq;
    logic [31:0] x_addr;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [2:0] rv,
                         input logic [2:0] er, input logic [31:0] rd, input logic mreq);
    chk({tag, "_gnt"},    32'(gnt_o),    32'(g));
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'(rv));
    chk({tag, "_err"},    32'(err_o),    32'(er));
    chk({tag, "_rdata"},  rdata_o,       rd);
    chk({tag, "_memreq"}, 32'(mem_req_o), 32'(mreq));
  endtask

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic [2:0] r, input logic g, input logic rv,
                     input logic e, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_i = r; mem_gnt_i = g; mem_rvalid_i = rv; mem_err_i = e; mem_rdata_i = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req_i = 3'b111; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_out("rst", 3'b000, 3'b000, 3'b000, 32'h0, 1'b0);
    chk("rst_addr",  mem_addr_o,  32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_webe",  32'({mem_we_o, mem_be_o}), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Response scoreboard: every rvalid_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rvalid_o !== '0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rvalid", 32'(rvalid_o), 32'h0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("sb_rvalid", 32'(rvalid_o), 32'(e.rv));
        chk("sb_err",    32'(err_o),    32'(e.err));
        chk("sb_rdata",  rdata_o,       e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    addr_i  = {32'h0000_1000, 32'h0000_0200, 32'h0000_0100};
    we_i    = 3'b010;
    be_i    = {4'hC, 4'h3, 4'hF};
    wdata_i = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    // All three requesting, immediate downstream grant, response at the
    // second wait cycle: grants rotate 0, 1, 2, 0.
    vt[0]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b001, 3'b000, 3'b000, 32'h0,         1'b1, 32'h100};
    vt[1]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0};
    vt[2]  = '{3'b111, 1'b1, 1'b1, 1'b0, 32'hA1A1_0001, 3'b000, 3'b001, 3'b000, 32'hA1A1_0001, 1'b0, 32'h0};
    vt[3]  = '{3'b111, 1'b1, 1'b1, 1'b1, 32'h5A5A_5A5A, 3'b010, 3'b000, 3'b000, 32'h0,         1'b1, 32'h200};
    vt[4]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0};
    vt[5]  = '{3'b111, 1'b1, 1'b1, 1'b0, 32'hA2A2_0002, 3'b000, 3'b010, 3'b000, 32'hA2A2_0002, 1'b0, 32'h0};
    vt[6]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b100, 3'b000, 3'b000, 32'h0,         1'b1, 32'h1000};
    vt[7]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0};
    vt[8]  = '{3'b111, 1'b1, 1'b1, 1'b1, 32'hA3A3_0003, 3'b000, 3'b100, 3'b100, 32'hA3A3_0003, 1'b0, 32'h0};
    vt[9]  = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b001, 3'b000, 3'b000, 32'h0,         1'b1, 32'h100};
    vt[10] = '{3'b111, 1'b1, 1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 3'b000, 32'h0,         1'b0, 32'h0};
    vt[11] = '{3'b111, 1'b1, 1'b1, 1'b0, 32'hA4A4_0004, 3'b000, 3'b001, 3'b000, 32'hA4A4_0004, 1'b0, 32'h0};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      if (vt[i].x_rv != 3'b000) sb.push_back('{vt[i].x_rv, vt[i].x_err, vt[i].x_rdata});
      cyc(vt[i].req, vt[i].gnt, vt[i].rv, vt[i].err, vt[i].rdata);
      chk_out($sformatf("vec%0d", i), vt[i].x_gnt, vt[i].x_rv, vt[i].x_err, vt[i].x_rdata, vt[i].x_mreq);
      if (vt[i].x_mreq) chk($sformatf("vec%0d_addr", i), mem_addr_o, vt[i].x_addr);
    end

    // Single read by requester 2.
    do_reset();
    cyc(3'b100, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("rd2_grant", 3'b100, 3'b000, 3'b000, 32'h0, 1'b1);
    chk("rd2_addr", mem_addr_o, 32'h0000_1000);
    chk("rd2_we_be", 32'({mem_we_o, mem_be_o}), 32'h0C);
    sb.push_back('{3'b100, 3'b000, 32'hDEAD_BEEF});
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_out("rd2_resp", 3'b000, 3'b100, 3'b000, 32'hDEAD_BEEF, 1'b0);

    // Timeout with no response: error at the 4th wait cycle.
    do_reset();
    cyc(3'b001, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("tmo_grant", 3'b001, 3'b000, 3'b000, 32'h0, 1'b1);
    for (int w = 0; w < TMO - 1; w++) begin
      cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_out($sformatf("tmo_wait%0d", w), 3'b000, 3'b000, 3'b000, 32'h0, 1'b0);
    end
    sb.push_back('{3'b001, 3'b001, 32'h0});
    cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("tmo_fire", 3'b000, 3'b001, 3'b001, 32'h0, 1'b0);
    // Back in IDLE the very next cycle; pointer moved past requester 0.
    cyc(3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("tmo_idle", 3'b000, 3'b000, 3'b000, 32'h0, 1'b1);
    chk("tmo_idle_addr", mem_addr_o, 32'h200);
    cyc(3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("race_grant", 3'b010, 3'b000, 3'b000, 32'h0, 1'b1);
    chk("race_wdata", mem_wdata_o, 32'h1111_1111);
    // Response arriving exactly at the timeout cycle wins, carrying its own error.
    for (int w = 0; w < TMO - 1; w++) cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    sb.push_back('{3'b010, 3'b000, 32'h1234_5678});
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    chk_out("race_resp", 3'b000, 3'b010, 3'b000, 32'h1234_5678, 1'b0);

    // Selection frozen while waiting for the downstream grant.
    do_reset();
    cyc(3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("hold_req", 3'b000, 3'b000, 3'b000, 32'h0, 1'b1);
    chk("hold_req_addr", mem_addr_o, 32'h200);
    cyc(3'b011, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hold_keep_addr", mem_addr_o, 32'h200);
    cyc(3'b011, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("hold_grant", 3'b010, 3'b000, 3'b000, 32'h0, 1'b1);
    chk("hold_grant_addr", mem_addr_o, 32'h200);
    chk("hold_we_be", 32'({mem_we_o, mem_be_o}), 32'h13);
    sb.push_back('{3'b010, 3'b010, 32'h0000_0055});
    cyc(3'b000, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
    chk_out("hold_resp", 3'b000, 3'b010, 3'b010, 32'h55, 1'b0);
    // Withdrawn request returns to IDLE without moving the pointer (now 2).
    cyc(3'b001, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_req_addr", mem_addr_o, 32'h100);
    cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("drop", 3'b000, 3'b000, 3'b000, 32'h0, 1'b0);
    cyc(3'b011, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("drop_regrant", 3'b001, 3'b000, 3'b000, 32'h0, 1'b1);
    sb.push_back('{3'b001, 3'b000, 32'h0000_0077});
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'h0000_0077);
    chk_out("drop_resp", 3'b000, 3'b001, 3'b000, 32'h77, 1'b0);

    // Reset in the middle of a wait abandons the transaction.
    do_reset();
    cyc(3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("abort_grant", 3'b010, 3'b000, 3'b000, 32'h0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    do_reset();
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0);
    chk_out("abort_late_rvalid", 3'b000, 3'b000, 3'b000, 32'h0, 1'b0);
    cyc(3'b111, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("abort_ptr0", 3'b001, 3'b000, 3'b000, 32'h0, 1'b1);
    // Minimum latency: response in the first cycle after the grant.
    sb.push_back('{3'b001, 3'b000, 32'hCAFE_F00D});
    cyc(3'b000, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
    chk_out("minlat_resp", 3'b000, 3'b001, 3'b000, 32'hCAFE_F00D, 1'b0);

    cyc(3'b000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
